button_debounce: RTL and testbench

Multi-button debouncer and edge detector for the bop-it input path. It sits directly downstream of the 500 Hz tick divider and uses that divider's single-cycle `tick` pulse as its sample enable. Each raw pushbutton is synchronised to `clk`, filtered until it holds a new level for `STABLE_TICKS` consecutive ticks, and reported as a clean level plus one-cycle press/release pulses. These outputs feed the game FSM.

---
 rtl/bopit_pkg.sv | 12 +
 rtl/debounce_cell.sv | 83 ++++++++
 rtl/button_debounce.sv | 44 ++++
 tb/tb_button_debounce.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bopit_pkg.sv
// Shared constants for the bop-it input path. The tick divider, the
// debouncer and the game FSM all take their defaults from here so the
// debounce window and button count stay consistent across the design.
package bopit_pkg;

  // Consecutive disagreeing 500 Hz samples needed to accept a new level (8 ms).
  localparam int DEBOUNCE_TICKS_DEFAULT = 4;

  // Number of physical pushbuttons on the board.
  localparam int N_BTN_DEFAULT = 4;

endpackage

// File: rtl/debounce_cell.sv
// One-button debouncer: 2-flop synchroniser, stable-sample counter, debounced
// level and one-cycle press/release pulse registers. The counter advances
// only on sample ticks and restarts whenever a sample agrees with the level.
module debounce_cell import bopit_pkg::*; #(
  parameter int STABLE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic press_next
);

  localparam int                CNT_W   = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_TICKS - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Two-stage synchroniser for the asynchronous button input, runs every clk.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours; blocking here would
  // collapse the two synchroniser stages into one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Next-state: count disagreeing samples, flip the level on the last one.
  // NOTE: every output gets a default before any branch, otherwise paths
  // that skip an assignment would infer a latch.
  always_comb begin
    level_d   = level_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        level_d   = sync2_q;
        cnt_d     = '0;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Level, counter and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  // Exposed so the parent can register any_press on the same edge as the pulse.
  assign press_next  = press_d;

endmodule

// File: rtl/button_debounce.sv
// Multi-button debouncer and edge detector. Instantiates one debounce_cell
// per button and registers the OR of the press pulses alongside them.
module button_debounce import bopit_pkg::*; #(
  parameter int N_BTN        = N_BTN_DEFAULT,
  parameter int STABLE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  logic [N_BTN-1:0] press_next;
  logic             any_press_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    debounce_cell #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .press_next  (press_next[i])
    );
  end

  // any_press is built from the cells' next-state pulses so it lands on the
  // same edge as btn_press rather than one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) any_press_q <= 1'b0;
    else        any_press_q <= |press_next;
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus randomized stimulus,
// checked against a run-length reference model of the debounce rules.
module tb_button_debounce;
  localparam int NB = 4;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release;
  logic          any_press;

  button_debounce #(.N_BTN(NB), .STABLE_TICKS(ST)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .any_press   (any_press)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit tick_en   = 1'b0;
  bit rand_tick = 1'b0;
  int phase     = 0;

  // Reference model: raw input reaches the sampler two clk later; a button
  // flips once ST consecutive tick samples disagree with its level.
  logic [NB-1:0] m_h1 = '0, m_h2 = '0;
  logic [NB-1:0] m_level = '0, m_press = '0, m_rel = '0;
  logic          m_any = 1'b0;
  int            run [NB];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_h1 = '0; m_h2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_any = 1'b0;
      for (int i = 0; i < NB; i++) run[i] = 0;
    end else begin
      m_press = '0;
      m_rel   = '0;
      if (tick) begin
        for (int i = 0; i < NB; i++) begin
          if (m_h2[i] != m_level[i]) begin
            run[i] = run[i] + 1;
            if (run[i] == ST) begin
              m_level[i] = m_h2[i];
              if (m_h2[i]) m_press[i] = 1'b1;
              else         m_rel[i]   = 1'b1;
              run[i] = 0;
            end
          end else begin
            run[i] = 0;
          end
        end
      end
      m_any = |m_press;
      m_h2  = m_h1;
      m_h1  = btn_raw;
    end
  end

  wire [3*NB:0] obs = {btn_level, btn_press, btn_release, any_press};
  wire [3*NB:0] exp_v = {m_level, m_press, m_rel, m_any};

  // Drive tick for the coming edge, then wait until just after that edge.
  task automatic advance();
    if (rand_tick) tick = ($urandom_range(0, 2) == 0);
    else           tick = tick_en && (phase == 9);
    phase = (phase + 1) % 10;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    btn_raw = '0;
    advance();
    advance();
    rst_n = 1'b1;
    phase = 0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    tick_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      btn_raw = NB'($urandom);
      advance();
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got %h want 0", obs);
      end
    end
    rst_n = 1'b1;
    phase = 0;
  endtask

  task automatic test_clean_press();
    int k, nt;
    logic exp_p;
    do_reset();
    tick_en = 1'b1;
    btn_raw = 4'b0001;
    k = 0; nt = 0;
    for (int c = 0; c < 80; c++) begin
      advance();
      k++;
      if (tick && k >= 3) nt++;
      exp_p = tick && k >= 3 && nt == ST;
      total++;
      if (btn_press[0] !== exp_p) begin
        bad++;
        $display("FAIL clean_press_pulse: cycle %0d got %b want %b", c, btn_press[0], exp_p);
      end
      total++;
      if (any_press !== exp_p) begin
        bad++;
        $display("FAIL clean_any_press: cycle %0d got %b want %b", c, any_press, exp_p);
      end
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL clean_model: cycle %0d got %h want %h", c, obs, exp_v);
      end
    end
    total++;
    if (btn_level !== 4'b0001) begin
      bad++;
      $display("FAIL clean_level: got %b want 0001", btn_level);
    end
  endtask

  task automatic test_bounce();
    bit pat [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int np;
    np = 0;
    for (int p = 0; p < 4; p++) begin
      btn_raw[1] = pat[p];
      for (int c = 0; c < 10; c++) begin
        advance();
        total++;
        if (btn_press[1] !== 1'b0 || btn_level[1] !== 1'b0) begin
          bad++;
          $display("FAIL bounce_early_flip: got level=%b press=%b want 0/0", btn_level[1], btn_press[1]);
        end
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL bounce_model: got %h want %h", obs, exp_v);
        end
      end
    end
    btn_raw[1] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      advance();
      if (btn_press[1]) np++;
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL bounce_hold_model: got %h want %h", obs, exp_v);
      end
    end
    total++;
    if (np != 1 || btn_level[1] !== 1'b1) begin
      bad++;
      $display("FAIL bounce_single_press: got presses=%0d level=%b want 1/1", np, btn_level[1]);
    end
  endtask

  task automatic test_release();
    int nr, np;
    do_reset();
    tick_en = 1'b1;
    btn_raw = 4'b0010;
    for (int c = 0; c < 60; c++) advance();
    total++;
    if (btn_level !== 4'b0010) begin
      bad++;
      $display("FAIL release_setup_level: got %b want 0010", btn_level);
    end
    btn_raw = 4'b0000;
    nr = 0; np = 0;
    for (int c = 0; c < 60; c++) begin
      advance();
      if (btn_release[1]) nr++;
      if (btn_press != '0) np++;
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL release_model: got %h want %h", obs, exp_v);
      end
    end
    total++;
    if (nr != 1 || np != 0 || btn_level !== 4'b0000) begin
      bad++;
      $display("FAIL release_pulse: got releases=%0d presses=%0d level=%b want 1/0/0000", nr, np, btn_level);
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    do_reset();
    tick_en = 1'b1;
    btn_raw = 4'b1111;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      advance();
      if (btn_press != '0) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL simul_timeout: got no press want 1111 within 100 cycles");
    end else begin
      total++;
      if (btn_press !== 4'b1111 || any_press !== 1'b1) begin
        bad++;
        $display("FAIL simul_press: got %b any=%b want 1111 any=1", btn_press, any_press);
      end
      advance();
      total++;
      if (btn_press !== 4'b0000 || any_press !== 1'b0) begin
        bad++;
        $display("FAIL simul_clear: got %b any=%b want 0000 any=0", btn_press, any_press);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k, nt;
    logic exp_p;
    do_reset();
    tick_en = 1'b1;
    btn_raw = 4'b0001;
    k = 0; nt = 0;
    for (int c = 0; c < 100 && nt < 2; c++) begin
      advance();
      k++;
      if (tick && k >= 3) nt++;
    end
    rst_n = 1'b0;
    advance();
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h want 0", obs);
    end
    rst_n = 1'b1;
    k = 0; nt = 0;
    for (int c = 0; c < 80; c++) begin
      advance();
      k++;
      if (tick && k >= 3) nt++;
      exp_p = tick && k >= 3 && nt == ST;
      total++;
      if (btn_press[0] !== exp_p) begin
        bad++;
        $display("FAIL midreset_press: cycle %0d got %b want %b", c, btn_press[0], exp_p);
      end
    end
  endtask

  task automatic test_no_tick();
    do_reset();
    tick_en = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      btn_raw = NB'($urandom);
      advance();
      total++;
      if (btn_level !== '0 || btn_press !== '0 || btn_release !== '0) begin
        bad++;
        $display("FAIL no_tick: cycle %0d got lvl=%b prs=%b rel=%b want 0", c, btn_level, btn_press, btn_release);
      end
    end
  endtask

  task automatic test_random(input bit rt);
    do_reset();
    tick_en   = 1'b1;
    rand_tick = rt;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) btn_raw[$urandom_range(0, NB - 1)] ^= 1'b1;
      advance();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL random_model: rt=%0d cycle %0d got %h want %h", rt, c, obs, exp_v);
      end
    end
    rand_tick = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NB; i++) run[i] = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_no_tick();
    test_random(1'b0);
    test_random(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
